// File: rtl/dbus_wb_bridge.sv
// ---------------------------------------------------------------------------
// dbus_wb_bridge
//
// Bridges a data-cache memory port (cmd/rsp handshake) onto a Wishbone B4
// classic master. Writes are single-beat and return no response beat. Reads
// are bursts of length+1 incrementing word addresses, one rsp beat per
// Wishbone beat. A per-beat watchdog turns a silent slave into an error beat.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   io_mem_cmd_*               command from the cache (valid/ready handshake)
//   io_mem_rsp_*               registered read response beats
//   wb_*                       Wishbone classic master
//   io_write_error             one-cycle pulse when a write ends in error
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module dbus_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  // data-cache command side
  input  logic        io_mem_cmd_valid,
  output logic        io_mem_cmd_ready,
  input  logic        io_mem_cmd_payload_wr,
  input  logic [31:0] io_mem_cmd_payload_address,
  input  logic [31:0] io_mem_cmd_payload_data,
  input  logic [3:0]  io_mem_cmd_payload_mask,
  input  logic [2:0]  io_mem_cmd_payload_length,
  input  logic        io_mem_cmd_payload_last,
  // response side
  output logic        io_mem_rsp_valid,
  output logic [31:0] io_mem_rsp_payload_data,
  output logic        io_mem_rsp_payload_error,
  // Wishbone master
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_r,
  input  logic        wb_ack,
  input  logic        wb_err,
  // write error pulse
  output logic        io_write_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam logic [9:0] TIMEOUT_LIM = 10'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [31:0] dat_w_q, dat_w_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  beats_left_q, beats_left_d;
  logic [9:0]  to_cnt_q, to_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;
  logic        write_error_q, write_error_d;

  // Address byte offset and the last flag carry no information for a
  // word-wide, single-beat-write bus.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{io_mem_cmd_payload_last, io_mem_cmd_payload_address[1:0]};

  // Slave responses only count while a beat is actually being strobed.
  logic cmd_accept;
  logic ack_seen;
  logic err_seen;
  logic timed_out;
  logic beat_err;
  logic beat_done;

  assign cmd_accept = io_mem_cmd_valid && cmd_ready_q;
  assign ack_seen   = cyc_q && wb_ack;
  assign err_seen   = cyc_q && wb_err;
  assign timed_out  = cyc_q && (to_cnt_q == TIMEOUT_LIM);
  // err (or watchdog) wins over a simultaneous ack.
  assign beat_err   = err_seen || timed_out;
  assign beat_done  = ack_seen || beat_err;

  always_comb begin
    // NOTE: every *_d gets a default here, before any branching, so no path
    // through this block can leave a value unassigned and infer a latch.
    state_d       = state_q;
    cyc_d         = cyc_q;
    we_d          = we_q;
    adr_d         = adr_q;
    dat_w_d       = dat_w_q;
    sel_d         = sel_q;
    beats_left_d  = beats_left_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = '0;
    rsp_error_d   = 1'b0;
    write_error_d = 1'b0;
    // Watchdog counts idle strobe cycles of the current beat only.
    to_cnt_d      = (cyc_q && !beat_done) ? to_cnt_q + 10'd1 : '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          cyc_d        = 1'b1;
          we_d         = io_mem_cmd_payload_wr;
          adr_d        = io_mem_cmd_payload_address[31:2];
          dat_w_d      = io_mem_cmd_payload_data;
          sel_d        = io_mem_cmd_payload_wr ? io_mem_cmd_payload_mask : 4'hF;
          beats_left_d = io_mem_cmd_payload_wr ? 3'd0 : io_mem_cmd_payload_length;
          state_d      = io_mem_cmd_payload_wr ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        if (beat_done) begin
          cyc_d         = 1'b0;
          write_error_d = beat_err;
          state_d       = ST_IDLE;
        end
      end

      ST_READ: begin
        if (beat_done) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = beat_err ? 32'h0 : wb_dat_r;
          rsp_error_d = beat_err;
          if (beats_left_q == 3'd0) begin
            cyc_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            // Errored beats do not abort the burst; the 30-bit add wraps.
            adr_d        = adr_q + 30'd1;
            beats_left_d = beats_left_q - 3'd1;
          end
        end
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Ready is registered so it stays low while reset is held and rises on
    // the first edge afterwards; it tracks "next state is IDLE".
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= '0;
      dat_w_q       <= '0;
      sel_q         <= '0;
      beats_left_q  <= '0;
      to_cnt_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      write_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      dat_w_q       <= dat_w_d;
      sel_q         <= sel_d;
      beats_left_q  <= beats_left_d;
      to_cnt_q      <= to_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      write_error_q <= write_error_d;
    end
  end

  // Single-master classic cycles: cyc and stb always rise and fall together.
  assign io_mem_cmd_ready         = cmd_ready_q;
  assign wb_cyc                   = cyc_q;
  assign wb_stb                   = cyc_q;
  assign wb_we                    = we_q;
  assign wb_adr                   = adr_q;
  assign wb_dat_w                 = dat_w_q;
  assign wb_sel                   = sel_q;
  assign io_mem_rsp_valid         = rsp_valid_q;
  assign io_mem_rsp_payload_data  = rsp_data_q;
  assign io_mem_rsp_payload_error = rsp_error_q;
  assign io_write_error           = write_error_q;

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// ---------------------------------------------------------------------------
// tb_dbus_wb_bridge
//
// Self-checking bench for dbus_wb_bridge (TIMEOUT_CYCLES = 4). A reactive
// Wishbone slave answers each beat according to a per-beat plan (ack, err,
// ack+err, or silence) after a planned delay, and toggles ack/err noise while
// stb is low. Expected beats, data and cycle numbers are computed from the
// plan: beat i ends `delay` (or TIMEOUT) cycles after it starts, its rsp
// appears one cycle later, and the next beat starts that same cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dbus_wb_bridge;

  localparam int TO = 4;

  typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [29:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_w;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_mask;
  logic [2:0]  cmd_len;
  logic        cmd_last;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;
  logic        write_error;

  dbus_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .io_mem_cmd_valid           (cmd_valid),
    .io_mem_cmd_ready           (cmd_ready),
    .io_mem_cmd_payload_wr      (cmd_wr),
    .io_mem_cmd_payload_address (cmd_addr),
    .io_mem_cmd_payload_data    (cmd_data),
    .io_mem_cmd_payload_mask    (cmd_mask),
    .io_mem_cmd_payload_length  (cmd_len),
    .io_mem_cmd_payload_last    (cmd_last),
    .io_mem_rsp_valid           (rsp_valid),
    .io_mem_rsp_payload_data    (rsp_data),
    .io_mem_rsp_payload_error   (rsp_err),
    .wb_cyc                     (wb_cyc),
    .wb_stb                     (wb_stb),
    .wb_we                      (wb_we),
    .wb_adr                     (wb_adr),
    .wb_dat_w                   (wb_dat_w),
    .wb_sel                     (wb_sel),
    .wb_dat_r                   (wb_dat_r),
    .wb_ack                     (wb_ack),
    .wb_err                     (wb_err),
    .io_write_error             (write_error)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave read data is a unique tag of the word address.
  function automatic logic [31:0] word_tag(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hC3A5_0F00;
  endfunction

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  rsp_t rsp_q[$];
  int   werr_q[$];
  int   idle_bad = 0;

  always @(negedge clk) begin
    if (rsp_valid) rsp_q.push_back('{data: rsp_data, err: rsp_err, cyc: cyc_cnt});
    else if (rsp_data != 32'h0) idle_bad++;
    if (write_error) werr_q.push_back(cyc_cnt);
  end

  // ---------------- reactive slave ----------------
  kind_e plan_kind[8];
  int    plan_delay[8];
  bit    noise_en;
  beat_t beat_q[$];
  int    s_idx = 0;
  int    s_cnt = 0;
  bit    s_stb_last = 1'b0;
  bit    s_drove = 1'b0;

  always @(negedge clk) begin
    // Account for what the posedge just past did to the current beat.
    if (!s_stb_last) begin
      s_idx = 0;
      s_cnt = 0;
    end else if (s_drove || s_cnt == TO) begin
      s_idx = (s_idx + 1) % 8;
      s_cnt = 0;
    end else begin
      s_cnt++;
    end
    s_stb_last = wb_stb;
    s_drove    = 1'b0;
    wb_ack     = 1'b0;
    wb_err     = 1'b0;
    wb_dat_r   = $urandom;
    if (wb_stb) begin
      if (s_cnt == 0) beat_q.push_back('{adr: wb_adr, we: wb_we, sel: wb_sel, dat_w: wb_dat_w});
      if (plan_kind[s_idx] != K_NONE && s_cnt == plan_delay[s_idx]) begin
        s_drove = 1'b1;
        wb_ack  = plan_kind[s_idx] inside {K_ACK, K_BOTH};
        wb_err  = plan_kind[s_idx] inside {K_ERR, K_BOTH};
        if (plan_kind[s_idx] == K_ACK) wb_dat_r = word_tag(wb_adr);
      end
    end else if (noise_en) begin
      wb_ack = ($urandom_range(3) == 0);
      wb_err = ($urandom_range(3) == 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_plan(input kind_e k, input int d);
    for (int i = 0; i < 8; i++) begin
      plan_kind[i]  = k;
      plan_delay[i] = d;
    end
  endtask

  task automatic wait_ready(input string name);
    int waited;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    check(name, cmd_ready, 1'b1);
  endtask

  // Issue one command, wait for the bridge to go idle, compare with the plan.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input int len);
    int          n, base_r, base_w, base_b, base_idle, c, s, t, ready_cyc;
    logic [29:0] a;
    bit          is_err;
    wait_ready("cmd_ready_before");
    base_r    = rsp_q.size();
    base_w    = werr_q.size();
    base_b    = beat_q.size();
    base_idle = idle_bad;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    cmd_len   = 3'(len);
    cmd_last  = 1'($urandom);
    c         = cyc_cnt;
    step();
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_data  = $urandom;
    cmd_mask  = 4'($urandom);
    cmd_len   = 3'($urandom);
    wait_ready("cmd_ready_return");
    ready_cyc = cyc_cnt;

    n = wr ? 1 : len + 1;
    s = c + 1;
    a = addr[31:2];
    check("rsp_beats", rsp_q.size() - base_r, wr ? 0 : n);
    check("wb_beats", beat_q.size() - base_b, n);
    for (int i = 0; i < n; i++) begin
      is_err = (plan_kind[i] != K_ACK);
      t = s + ((plan_kind[i] == K_NONE) ? TO : plan_delay[i]);
      if (base_b + i < beat_q.size()) begin
        check("wb_adr", beat_q[base_b + i].adr, a);
        check("wb_we", beat_q[base_b + i].we, wr);
        check("wb_sel", beat_q[base_b + i].sel, wr ? mask : 4'hF);
        if (wr) check("wb_dat_w", beat_q[base_b + i].dat_w, data);
      end
      if (!wr && base_r + i < rsp_q.size()) begin
        check("rsp_data", rsp_q[base_r + i].data, is_err ? 32'h0 : word_tag(a));
        check("rsp_error", rsp_q[base_r + i].err, is_err);
        check("rsp_cycle", rsp_q[base_r + i].cyc, t + 1);
      end
      if (wr) begin
        check("wr_err_pulses", werr_q.size() - base_w, is_err ? 1 : 0);
        if (is_err && base_w < werr_q.size()) check("wr_err_cycle", werr_q[base_w], t + 1);
      end
      s = t + 1;
      a = a + 30'd1;
    end
    check("ready_cycle", ready_cyc, s);
    check("rsp_idle_data", idle_bad - base_idle, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          base_r;
    int          waited;
    int          r;
    bit          wr;
    logic [31:0] addr;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_mask  = '0;
    cmd_len   = '0;
    cmd_last  = 1'b0;
    noise_en  = 1'b1;
    set_plan(K_ACK, 0);

    // Reset state
    repeat (3) step();
    check("rst_wb_cyc", wb_cyc, 1'b0);
    check("rst_wb_stb", wb_stb, 1'b0);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_adr", wb_adr, 30'h0);
    check("rst_wb_dat_w", wb_dat_w, 32'h0);
    check("rst_wb_sel", wb_sel, 4'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_write_error", write_error, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    reset = 1'b1;
    step();
    check("ready_first_edge", cmd_ready, 1'b1);

    // Write with ack after 2 cycles
    set_plan(K_ACK, 2);
    run_txn(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0110, 0);

    // 8-beat read, ack every cycle
    set_plan(K_ACK, 0);
    run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 7);

    // 4-beat read, err on beat 2
    set_plan(K_ACK, 0);
    plan_kind[2] = K_ERR;
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'h3, 3);

    // Silent slave: read then write time out
    set_plan(K_NONE, 0);
    run_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 0);
    run_txn(1'b1, 32'h0000_0304, 32'h1234_5678, 4'hF, 0);

    // Address wrap at the top of the 30-bit word space
    set_plan(K_ACK, 1);
    run_txn(1'b0, 32'hFFFF_FFF8, 32'h0, 4'h0, 7);

    // Write with ack and err together, then a normal read
    set_plan(K_ACK, 0);
    plan_kind[0] = K_BOTH;
    run_txn(1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 4'b1001, 0);
    set_plan(K_ACK, 0);
    run_txn(1'b0, 32'h0000_0500, 32'h0, 4'h0, 2);

    // Reset after the third beat of an 8-beat read
    set_plan(K_ACK, 0);
    wait_ready("cmd_ready_rst_test");
    base_r    = rsp_q.size();
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = 32'h0000_2000;
    cmd_len   = 3'd7;
    step();
    cmd_valid = 1'b0;
    waited    = 0;
    while (rsp_q.size() - base_r < 3 && waited < 50) begin
      step();
      waited++;
    end
    check("pre_reset_beats", rsp_q.size() - base_r, 3);
    for (int i = 0; i < 3; i++)
      if (base_r + i < rsp_q.size())
        check("pre_reset_data", rsp_q[base_r + i].data, word_tag(30'h800 + 30'(i)));
    reset = 1'b0;
    #1;
    check("midrst_wb_cyc", wb_cyc, 1'b0);
    check("midrst_wb_stb", wb_stb, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    repeat (3) step();
    check("midrst_no_more_rsp", rsp_q.size() - base_r, 3);
    reset = 1'b1;
    step();
    check("postrst_ready", cmd_ready, 1'b1);
    check("postrst_wb_cyc", wb_cyc, 1'b0);
    run_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 7);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 8; j++) begin
        r = $urandom_range(9);
        plan_kind[j]  = (r < 6) ? K_ACK : (r == 6) ? K_ERR : (r == 7) ? K_BOTH : K_NONE;
        plan_delay[j] = $urandom_range(3);
      end
      wr   = ($urandom_range(2) == 0);
      addr = $urandom;
      if ($urandom_range(4) == 0) addr = 32'hFFFF_FFE0 | 32'($urandom_range(31));
      run_txn(wr, addr, $urandom, 4'($urandom), $urandom_range(7));
      repeat ($urandom_range(2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_wb_bridge.md
DBUS_WB_BRIDGE -- requirements
Module: dbus_wb_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, Wishbone cycles allowed with stb high and no ack/err before the bridge forces an error (range 1..1023).
REQ-002 One clock; reset is asynchronous and active-low; the ports are clk and reset.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  asynchronous active-low reset.
REQ-005 Ports (data-cache memory side):
- io_mem_cmd_valid  in  1
- io_mem_cmd_ready  out  1
- io_mem_cmd_payload_wr  in  1
- io_mem_cmd_payload_address  in  32
- io_mem_cmd_payload_data  in  32
- io_mem_cmd_payload_mask  in  4
- io_mem_cmd_payload_length  in  3  (read beats minus 1)
- io_mem_cmd_payload_last  in  1
REQ-006 Ports (response side): io_mem_rsp_valid out 1; io_mem_rsp_payload_data out 32; io_mem_rsp_payload_error out 1.
REQ-007 Ports (Wishbone B4 classic master):
- wb_cyc out 1; wb_stb out 1; wb_we out 1
- wb_adr out 30 (word address); wb_dat_w out 32; wb_sel out 4
- wb_dat_r in 32; wb_ack in 1; wb_err in 1
REQ-008 Port: io_write_error  out  1  one-cycle pulse when a write ends in error.

Function
REQ-009 The FSM has three states: IDLE, WRITE and READ.
REQ-010 io_mem_cmd_ready is 1 only in IDLE; a command is accepted on valid&&ready; there is no command buffering.
REQ-011 On accept, the bridge latches wr, address[31:2], data, mask and length; address[1:0] is ignored; last is ignored (every write is single-beat).
REQ-012 Accept with wr=1 -> WRITE.
- wb_cyc=wb_stb=wb_we=1, wb_adr=address[31:2], wb_dat_w=data, wb_sel=mask, all starting the cycle after accept.
- The write produces no io_mem_rsp beat.
REQ-013 WRITE ends on wb_ack or wb_err or timeout.
- wb_cyc/wb_stb are 0 the following cycle and the state is IDLE.
- An err or timeout pulses io_write_error for 1 cycle, in the cycle after the terminating event.
REQ-014 Accept with wr=0 -> READ.
- Beat count = length+1 (1..8).
- Beat i drives wb_adr = address[31:2]+i, with 30-bit wrap modulo 2^30.
- wb_we=0, wb_sel=4'hF; the request mask is ignored.
REQ-015 In READ, wb_cyc and wb_stb stay high across beats. After each ack/err, wb_adr advances the next cycle, so the maximum rate is one beat per cycle.
REQ-016 Each read beat terminated at cycle T produces io_mem_rsp_valid=1 for exactly one cycle at T+1.
- On ack: data=wb_dat_r captured at T, error=0.
- On err or timeout: data=0, error=1.
REQ-017 An errored beat does not abort the burst; all length+1 beats are always returned, in address order.
REQ-018 After the final beat terminates, wb_cyc/wb_stb are 0 the next cycle and the state is IDLE. Its rsp beat and the reassertion of cmd_ready occur in that same cycle.
REQ-019 The timeout counter:
- counts cycles with wb_stb=1 and neither ack nor err;
- clears on each beat termination;
- on reaching TIMEOUT_CYCLES, the beat terminates as an error.
REQ-020 If wb_ack and wb_err are both 1 in the same cycle, err takes priority.
REQ-021 wb_ack/wb_err received while wb_stb=0 are ignored.
REQ-022 io_mem_rsp_* are registered outputs; io_mem_rsp_payload_data holds 0 when io_mem_rsp_valid=0.
REQ-023 Minimum latency: read command accepted at cycle C, with wb_ack asserted in the first stb cycle -> first io_mem_rsp_valid at C+2.

Reset
REQ-024 While reset=0, asynchronously:
- state=IDLE
- wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, wb_sel=0
- io_mem_rsp_valid=0, data=0, error=0
- io_write_error=0
- counters=0
- io_mem_cmd_ready=0
REQ-025 io_mem_cmd_ready=1 from the first clock edge after reset deasserts.
REQ-026 Reset mid-burst drops the transaction immediately: no further rsp beats, wb_cyc low at once, and no replay after reset.

Verification
REQ-027 Write address 0x0000_1008, data 0xDEADBEEF, mask 4'b0110, with ack after 2 cycles -> wb_adr=0x402, wb_sel=0110, wb_we=1; no rsp; cmd_ready back the cycle after ack.
REQ-028 Read address 0x0000_0100, length=7, ack every cycle returning adr-tagged data -> 8 rsp beats on consecutive cycles with data for wb_adr 0x40..0x47, error=0.
REQ-029 Read length=3, wb_err on beat 2 -> 4 rsp beats, beat 2 error=1 with data=0, others error=0.
REQ-030 TIMEOUT_CYCLES=4, read length=0, ack never asserted -> one rsp beat with error=1 exactly 5 cycles after stb rises; write of same -> io_write_error pulse.
REQ-031 Reset asserted after beat 3 of an 8-beat read -> wb_cyc=0 and rsp_valid=0 immediately; a new read after reset returns a full, correct burst.
REQ-032 Back-to-back write then read, with ack and err asserted together on the write -> io_write_error pulses, and the read then proceeds normally.
